// File: rtl/i2c_bus_arbiter_if.sv
// Requester-side and I2C-master-side signals of the shared I2C command port.
// The arbiter connects through the slave modport; the environment uses master.
interface i2c_bus_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_rw;
    logic [7*N_REQ-1:0] req_addr;
    logic [8*N_REQ-1:0] req_wdata;
    logic [N_REQ-1:0]   req_ready;
    logic [N_REQ-1:0]   rsp_valid;
    logic [7:0]         rsp_rdata;
    logic               rsp_err;
    logic               rsp_tmo;
    logic               m_valid;
    logic               m_ready;
    logic               m_rw;
    logic [6:0]         m_addr;
    logic [7:0]         m_wdata;
    logic               m_done;
    logic               m_nack;
    logic [7:0]         m_rdata;
    logic               m_abort;
    logic               busy;

    modport slave (
        input  req_valid, req_rw, req_addr, req_wdata,
        input  m_ready, m_done, m_nack, m_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_tmo,
        output m_valid, m_rw, m_addr, m_wdata, m_abort, busy
    );

    modport master (
        output req_valid, req_rw, req_addr, req_wdata,
        output m_ready, m_done, m_nack, m_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_tmo,
        input  m_valid, m_rw, m_addr, m_wdata, m_abort, busy
    );
endinterface

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one I2C master command port among N_REQ requesters,
// one transaction in flight, with a watchdog that aborts a hung bus.
module i2c_bus_arbiter #(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int TMO_W          = 17
) (
    input logic               clk,
    input logic               rst,
    i2c_bus_arbiter_if.slave  bus
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] cand;
    logic             pick_found;
    logic [TMO_W-1:0] tmo_cnt;

    // Scan downward in priority so the requester closest above rr_ptr is the last one written.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        cand       = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = IDX_W'((int'(rr_ptr) + i) % N_REQ);
            if (bus.req_valid[cand]) begin
                pick       = cand;
                pick_found = 1'b1;
            end
        end
    end

    assign bus.busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            winner        <= '0;
            tmo_cnt       <= '0;
            bus.req_ready <= '0;
            bus.rsp_valid <= '0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_tmo   <= 1'b0;
            bus.m_valid   <= 1'b0;
            bus.m_rw      <= 1'b0;
            bus.m_addr    <= '0;
            bus.m_wdata   <= '0;
            bus.m_abort   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        winner        <= pick;
                        bus.m_rw      <= bus.req_rw[pick];
                        bus.m_addr    <= bus.req_addr[int'(pick)*7 +: 7];
                        bus.m_wdata   <= bus.req_wdata[int'(pick)*8 +: 8];
                        bus.m_valid   <= 1'b1;
                        bus.req_ready <= N_REQ'(1) << pick;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.req_ready <= '0;
                    if (bus.m_valid && bus.m_ready) begin
                        bus.m_valid <= 1'b0;
                        tmo_cnt     <= '0;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    // A completion on the terminal watchdog cycle still counts as a normal finish.
                    if (bus.m_done) begin
                        bus.rsp_rdata <= (bus.m_rw && !bus.m_nack) ? bus.m_rdata : 8'h00;
                        bus.rsp_err   <= bus.m_nack;
                        bus.rsp_tmo   <= 1'b0;
                        bus.rsp_valid <= N_REQ'(1) << winner;
                        state         <= RESP;
                    end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        bus.m_abort   <= 1'b1;
                        bus.rsp_rdata <= 8'h00;
                        bus.rsp_err   <= 1'b1;
                        bus.rsp_tmo   <= 1'b1;
                        bus.rsp_valid <= N_REQ'(1) << winner;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    bus.rsp_valid <= '0;
                    bus.m_abort   <= 1'b0;
                    rr_ptr        <= (int'(winner) == N_REQ - 1) ? '0 : winner + 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed and randomized checks of i2c_bus_arbiter against a transaction-level
// model: round-robin winner choice, latency, response contents and watchdog abort.
module tb_i2c_bus_arbiter;
    localparam int N = 4;
    localparam int T = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    i2c_bus_arbiter_if #(.N_REQ(N)) bus ();

    i2c_bus_arbiter #(
        .N_REQ          (N),
        .TIMEOUT_CYCLES (T),
        .TMO_W          (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    logic [N-1:0] reqValid = '0;
    bit           fRw   [N];
    logic [6:0]   fAddr [N];
    logic [7:0]   fWd   [N];
    int           rrModel = 0;
    int           vectors = 0;
    int           miscompares = 0;

    always_comb begin
        bus.req_valid = reqValid;
        for (int i = 0; i < N; i++) begin
            bus.req_rw[i]           = fRw[i];
            bus.req_addr[7*i +: 7]  = fAddr[i];
            bus.req_wdata[8*i +: 8] = fWd[i];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int r, input bit rw, input logic [6:0] addr, input logic [7:0] wd);
        fRw[r]      = rw;
        fAddr[r]    = addr;
        fWd[r]      = wd;
        reqValid[r] = 1'b1;
    endtask

    // Round-robin rule: first pending requester at or above the pointer, wrapping.
    function automatic int pickWinner(input logic [N-1:0] v, input int rr);
        for (int i = 0; i < N; i++)
            if (v[(rr + i) % N]) return (rr + i) % N;
        return -1;
    endfunction

    function automatic logic [63:0] allOutputs();
        return 64'({bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.rsp_tmo,
                    bus.m_valid, bus.m_rw, bus.m_addr, bus.m_wdata, bus.m_abort, bus.busy});
    endfunction

    // Starts in IDLE with requests driven; ends in the first WAIT cycle.
    task automatic grantPhase(input int stall, output int w, output bit rw);
        logic [6:0] a;
        logic [7:0] d;
        w = pickWinner(reqValid, rrModel);
        if (w < 0) begin
            $display("[TB] FAIL no_request: observed none expected a pending requester");
            $fatal(1, "[TB] bench sequencing error");
        end
        rw = fRw[w];
        a  = fAddr[w];
        d  = fWd[w];
        bus.m_ready = 1'b0;
        tick();
        checkOutput("grant_ready", 64'(bus.req_ready), 64'(1 << w));
        checkOutput("grant_mvalid", 64'(bus.m_valid), 64'(1));
        checkOutput("grant_fields", 64'({bus.m_rw, bus.m_addr, bus.m_wdata}), 64'({rw, a, d}));
        checkOutput("grant_busy", 64'(bus.busy), 64'(1));
        for (int s = 0; s < stall; s++) begin
            bus.m_done = 1'($urandom_range(1, 0));
            bus.m_nack = 1'($urandom_range(1, 0));
            tick();
            checkOutput("stall_mvalid", 64'(bus.m_valid), 64'(1));
            checkOutput("stall_fields", 64'({bus.m_rw, bus.m_addr, bus.m_wdata}), 64'({rw, a, d}));
            checkOutput("stall_quiet", 64'({bus.req_ready, bus.rsp_valid, bus.m_abort}), 64'(0));
        end
        bus.m_done  = 1'b0;
        bus.m_nack  = 1'b0;
        bus.m_ready = 1'b1;
        reqValid[w] = 1'b0;
        tick();
        bus.m_ready = 1'b0;
        checkOutput("accept_drop", 64'({bus.m_valid, bus.req_ready}), 64'(0));
    endtask

    // doneAt is the WAIT cycle (1-based) carrying M_DONE; doneAt > T means never.
    task automatic completePhase(input int w, input bit rw, input int doneAt, input bit nack, input logic [7:0] rdata);
        bit timedOut;
        bit sent;
        int k;
        timedOut = (doneAt > T);
        sent = 1'b0;
        k = 1;
        while (k <= T && !sent) begin
            if (k == doneAt) begin
                bus.m_done  = 1'b1;
                bus.m_nack  = nack;
                bus.m_rdata = rdata;
                sent = 1'b1;
            end
            checkOutput("wait_quiet", 64'({bus.rsp_valid, bus.m_abort}), 64'(0));
            tick();
            bus.m_done  = 1'b0;
            bus.m_nack  = 1'b0;
            bus.m_rdata = 8'($urandom);
            k++;
        end
        checkOutput("rsp_valid", 64'(bus.rsp_valid), 64'(1 << w));
        checkOutput("rsp_err", 64'(bus.rsp_err), 64'(timedOut ? 1'b1 : nack));
        checkOutput("rsp_tmo", 64'(bus.rsp_tmo), 64'(timedOut));
        checkOutput("rsp_rdata", 64'(bus.rsp_rdata), 64'((!timedOut && rw && !nack) ? rdata : 8'h00));
        checkOutput("m_abort", 64'(bus.m_abort), 64'(timedOut));
        rrModel = (w + 1) % N;
        tick();
        checkOutput("idle_after", 64'({bus.rsp_valid, bus.m_abort, bus.busy}), 64'(0));
    endtask

    initial begin
        int  w;
        bit  rw;
        int  r;
        int  d;
        bus.m_ready = 1'b0;
        bus.m_done  = 1'b0;
        bus.m_nack  = 1'b0;
        bus.m_rdata = 8'h00;
        for (int i = 0; i < N; i++) begin
            fRw[i]   = 1'b0;
            fAddr[i] = 7'h00;
            fWd[i]   = 8'h00;
        end

        tick();
        checkOutput("reset_outputs", allOutputs(), 64'(0));
        tick();
        rst = 1'b0;
        tick();
        checkOutput("post_reset_idle", allOutputs(), 64'(0));

        $display("[TB] single read");
        applyStimulus(1, 1'b1, 7'h1D, 8'h00);
        grantPhase(0, w, rw);
        completePhase(w, rw, 5, 1'b0, 8'hA5);

        $display("[TB] reset during WAIT");
        applyStimulus(2, 1'b1, 7'h22, 8'h11);
        grantPhase(0, w, rw);
        tick();
        tick();
        rst = 1'b1;
        #1;
        checkOutput("async_reset", allOutputs(), 64'(0));
        for (int i = 0; i < 3; i++) begin
            bus.m_done = 1'b1;
            tick();
            checkOutput("reset_hold", allOutputs(), 64'(0));
        end
        bus.m_done = 1'b0;
        rst = 1'b0;
        rrModel = 0;
        for (int i = 0; i < N; i++) applyStimulus(i, 1'($urandom_range(1, 0)), 7'($urandom), 8'($urandom));
        grantPhase(1, w, rw);
        checkOutput("post_reset_grant", 64'(bus.m_addr === fAddr[0]), 64'(1));
        completePhase(w, rw, 2, 1'b0, 8'h5A);

        $display("[TB] nack write");
        reqValid = '0;
        tick();
        applyStimulus(3, 1'b0, 7'h50, 8'h3C);
        grantPhase(0, w, rw);
        checkOutput("nack_addr", 64'(bus.m_addr), 64'(7'h50));
        completePhase(w, rw, 3, 1'b1, 8'hFF);

        $display("[TB] timeout and terminal-cycle completion");
        reqValid = '0;
        applyStimulus(0, 1'b1, 7'h33, 8'h00);
        grantPhase(0, w, rw);
        completePhase(w, rw, T + 1, 1'b0, 8'h77);
        applyStimulus(0, 1'b1, 7'h34, 8'h00);
        grantPhase(0, w, rw);
        completePhase(w, rw, T, 1'b0, 8'h99);

        $display("[TB] stalls in ISSUE");
        applyStimulus(1, 1'b0, 7'h44, 8'hC3);
        grantPhase(10, w, rw);
        completePhase(w, rw, 4, 1'b0, 8'h00);
        applyStimulus(2, 1'b1, 7'h45, 8'h00);
        grantPhase(T + 4, w, rw);
        completePhase(w, rw, 1, 1'b0, 8'h81);

        $display("[TB] round robin with immediate re-requests");
        reqValid = '0;
        for (int n = 0; n < 4; n++) begin
            if (!reqValid[0]) applyStimulus(0, 1'b1, 7'h10, 8'h00);
            if (!reqValid[2]) applyStimulus(2, 1'b1, 7'h12, 8'h00);
            grantPhase(0, w, rw);
            completePhase(w, rw, 2, 1'b0, 8'(n));
        end
        reqValid = '0;
        applyStimulus(0, 1'b0, 7'h20, 8'h01);
        applyStimulus(1, 1'b0, 7'h21, 8'h02);
        applyStimulus(3, 1'b0, 7'h23, 8'h03);
        for (int n = 0; n < 3; n++) begin
            grantPhase(0, w, rw);
            completePhase(w, rw, 1, 1'b0, 8'h00);
        end

        $display("[TB] randomized transactions");
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < N; i++)
                if (!reqValid[i] && $urandom_range(1, 0) == 1)
                    applyStimulus(i, 1'($urandom_range(1, 0)), 7'($urandom), 8'($urandom));
            if (reqValid == '0)
                applyStimulus(int'($urandom_range(N - 1, 0)), 1'b1, 7'($urandom), 8'($urandom));
            grantPhase(int'($urandom_range(3, 0)), w, rw);
            r = int'($urandom_range(N - 1, 0));
            if (!reqValid[r] && r != w)
                applyStimulus(r, 1'($urandom_range(1, 0)), 7'($urandom), 8'($urandom));
            case ($urandom_range(9, 0))
                0:       d = T + 1;
                1:       d = T;
                default: d = int'($urandom_range(6, 1));
            endcase
            completePhase(w, rw, d, 1'($urandom_range(1, 0)), 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
